accel_mem_request_master: RTL
=============================

// Module: accel_mem_request_master
// PURPOSE
//  Accelerator-side initiator for the accel-to-memory bridge slave. Accepts one
//  memory request at a time on a valid/ready port and packs it into the bridge's
//  128-bit command word. Drives it as an Avalon-MM read or write and holds it
//  through waitrequest. Returns size-masked read data or a write ack on a response port.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles in ISSUE before abort (used only with ACCEL_REQ_TIMEOUT_EN)
// PORTS
//  clk                 in   1    single clock
//  reset               in   1    synchronous, active-high
//  req_valid           in   1    request present
//  req_ready           out  1    request accepted when valid&ready
//  req_write           in   1    1=write, 0=read
//  req_size            in   2    0=8b, 1=16b, 2=32b, 3=64b
//  req_addr            in   32   byte address; bits [30:0] used
//  req_wdata           in   64   write data, LSB-justified
//  rsp_valid           out  1    one-cycle response strobe
//  rsp_rdata           out  64   read data, zero-extended to size; 0 for writes
//  rsp_err             out  1    valid with rsp_valid: misaligned or timeout
//  avm_bridge_address  out  1    constant 0
//  avm_bridge_read     out  1    Avalon read
//  avm_bridge_write    out  1    Avalon write
//  avm_bridge_writedata out 128  command word
//  avm_bridge_readdata in   128  bridge data, already shifted right by addr[2:0]*8
//  avm_bridge_waitrequest in 1   stall
// BEHAVIOUR
//  Command word: [30:0]=addr[30:0]; [31]=0; [95:32]=wdata (unshifted); [96]=size==0;
//   [97]=size==1; [98]=size==3; [127:99]=0. Reads send the same word with wdata=0.
//  Reset: FSM=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; avm read/write=0;
//   writedata=0. Reset mid-transaction drops the request with no response.
//  FSM IDLE: req_ready=1. On accept, check alignment: 16b needs addr[0]=0;
//   32b needs addr[1:0]=0; 64b needs addr[2:0]=0.
//   Misaligned: -> RESP with rsp_err=1. No bus cycle is issued.
//   Aligned: register command word -> ISSUE.
//  ISSUE: req_ready=0. avm_bridge_read or avm_bridge_write=1 (registered, first
//   asserted the cycle after accept). Address, writedata and read/write stay stable
//   while waitrequest=1. When waitrequest=0, the transfer completes in that cycle:
//   capture readdata[63:0] masked to size (8/16/32/64 LSBs, upper bits zero),
//   deassert read/write next cycle, -> RESP.
//  RESP: rsp_valid=1 for exactly one cycle. rsp_err reflects the cause. rsp_rdata=0 for
//   writes and errors. -> IDLE. req_ready returns to 1 the following cycle.
//  Latency with waitrequest=0 throughout: accept at T, bus strobe at T+1,
//   rsp_valid at T+2, next accept at T+3.
//  avm_bridge_read and avm_bridge_write are never both 1. req_* is ignored outside IDLE.
//  rsp_valid and rsp_err are 0 in every cycle outside RESP.
// CONFIGURATION
//  ACCEL_REQ_TIMEOUT_EN defined:
//   - ISSUE counts cycles with waitrequest=1.
//   - At TIMEOUT_CYCLES, deassert read/write next cycle -> RESP with rsp_err=1,
//     rsp_rdata=0. waitrequest falling in the same cycle as expiry counts as success.
//  Undefined: no counter; ISSUE waits indefinitely. rsp_err is set only by misalignment.
// TESTING
//  1. write size=2, addr=0x100, wdata=0xDEADBEEF, waitrequest=0 -> writedata =
//     {29'h0,3'b000,32'h0,32'hDEADBEEF,1'b0,31'h100}; write=1 for exactly one cycle;
//     rsp_valid at T+2 with rsp_err=0, rsp_rdata=0.
//  2. read size=0, addr=0x103, readdata[63:0]=0x...A5 -> writedata[96]=1;
//     rsp_rdata=0x00000000000000A5.
//  3. read size=3, addr=0x8, waitrequest high 5 cycles -> read and writedata held
//     stable 6 cycles; req_ready=0 throughout; writedata[98]=1; single rsp_valid.
//  4. read size=2, addr=0x102 -> no read or write strobe; rsp_valid with rsp_err=1
//     at T+1.
//  5. ACCEL_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, waitrequest stuck 1 -> strobe drops
//     after 16 cycles; rsp_err=1. Without the macro -> no response after 1000 cycles.
//  6. reset asserted during ISSUE -> next cycle read=write=0, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/accel_mem_request_master_if.sv
// Request/response port and Avalon-MM bridge bus of the accelerator memory request master.
// The master modport is the DUT view and the slave modport is the environment view.
interface accel_mem_request_master_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CMD_W   = 128;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              avm_bridge_address;
    logic              avm_bridge_read;
    logic              avm_bridge_write;
    logic [CMD_W-1:0]  avm_bridge_writedata;
    logic [CMD_W-1:0]  avm_bridge_readdata;
    logic              avm_bridge_waitrequest;

    modport master (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output avm_bridge_address, avm_bridge_read, avm_bridge_write, avm_bridge_writedata,
        input  avm_bridge_readdata, avm_bridge_waitrequest
    );

    modport slave (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  avm_bridge_address, avm_bridge_read, avm_bridge_write, avm_bridge_writedata,
        output avm_bridge_readdata, avm_bridge_waitrequest
    );
endinterface

// File: rtl/accel_mem_request_master.sv
// Single-outstanding accelerator request master: packs requests into the bridge command word
// and runs one Avalon-MM cycle each. Optional ISSUE timeout is enabled by ACCEL_REQ_TIMEOUT_EN.
module accel_mem_request_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic                        clk,
    input logic                        reset,
    accel_mem_request_master_if.master bus
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CMD_W  = 128;

    typedef struct packed {
        logic [28:0]       rsvd;
        logic              sz64;
        logic              sz16;
        logic              sz8;
        logic [DATA_W-1:0] wdata;
        logic              addr_hi;
        logic [30:0]       addr;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    cmd_t              cmd_q, cmd_d;
    cmd_t              cmd_c;
    logic              misaligned_c;
    logic [DATA_W-1:0] rdata_masked_c;
    logic              unused_ok_c;

`ifdef ACCEL_REQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    assign unused_ok_c = ^{bus.avm_bridge_readdata[CMD_W-1:DATA_W], bus.req_addr[31]};

    // Command word and alignment check for the request on the port this cycle
    always_comb begin
        cmd_c         = '0;
        cmd_c.addr    = bus.req_addr[30:0];
        cmd_c.wdata   = bus.req_write ? bus.req_wdata : '0;
        cmd_c.sz8     = (bus.req_size == 2'd0);
        cmd_c.sz16    = (bus.req_size == 2'd1);
        cmd_c.sz64    = (bus.req_size == 2'd3);
        misaligned_c  = ((bus.req_size == 2'd1) &&  bus.req_addr[0])   ||
                        ((bus.req_size == 2'd2) && |bus.req_addr[1:0]) ||
                        ((bus.req_size == 2'd3) && |bus.req_addr[2:0]);
    end

    // Read data masked to the size latched in the command word
    always_comb begin
        rdata_masked_c = bus.avm_bridge_readdata[DATA_W-1:0];
        if (cmd_q.sz8) begin
            rdata_masked_c = DATA_W'(bus.avm_bridge_readdata[7:0]);
        end else if (cmd_q.sz16) begin
            rdata_masked_c = DATA_W'(bus.avm_bridge_readdata[15:0]);
        end else if (!cmd_q.sz64) begin
            rdata_masked_c = DATA_W'(bus.avm_bridge_readdata[31:0]);
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        read_d      = read_q;
        write_d     = write_q;
        cmd_d       = cmd_q;
`ifdef ACCEL_REQ_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (misaligned_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        cmd_d   = cmd_c;
                        read_d  = !bus.req_write;
                        write_d = bus.req_write;
                    end
                end
            end
            ISSUE: begin
                if (!bus.avm_bridge_waitrequest) begin
                    state_d     = RESP;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = read_q ? rdata_masked_c : '0;
                end
`ifdef ACCEL_REQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                read_d      = 1'b0;
                write_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            cmd_q       <= '0;
`ifdef ACCEL_REQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            cmd_q       <= cmd_d;
`ifdef ACCEL_REQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.req_ready            = req_ready_q;
    assign bus.rsp_valid            = rsp_valid_q;
    assign bus.rsp_err              = rsp_err_q;
    assign bus.rsp_rdata            = rsp_rdata_q;
    assign bus.avm_bridge_address   = 1'b0;
    assign bus.avm_bridge_read      = read_q;
    assign bus.avm_bridge_write     = write_q;
    assign bus.avm_bridge_writedata = cmd_q;
endmodule
